// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, read-mode constants and width helper for fifo_flex
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH        = 8;
  localparam int FIFO_INDEX_WIDTH       = 4;
  localparam int FIFO_ALMOST_FULL_THR   = 12;
  localparam int FIFO_ALMOST_EMPTY_THR  = 4;

  localparam int MODE_STANDARD = 0;
  localparam int MODE_FWFT     = 1;

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int count_width(input int index_width);
    return index_width + 1;
  endfunction

endpackage

// File: rtl/fifo_flex_mem.sv
// rtl/fifo_flex_mem.sv - simple dual-port register array, sync write, async read
module fifo_flex_mem #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << INDEX_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset so this can be replaced by a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised FIFO core with standard or FWFT read, count and sticky error flags
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH             = FIFO_DATA_WIDTH,
  parameter int INDEX_WIDTH            = FIFO_INDEX_WIDTH,
  parameter int ALMOST_FULL_THRESHOLD  = FIFO_ALMOST_FULL_THR,
  parameter int ALMOST_EMPTY_THRESHOLD = FIFO_ALMOST_EMPTY_THR,
  parameter int FWFT                   = MODE_STANDARD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [INDEX_WIDTH:0]   count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  localparam int CW    = count_width(INDEX_WIDTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESHOLD);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THRESHOLD);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  if (INDEX_WIDTH < 1) begin : g_chk_index
    $error("fifo_flex: INDEX_WIDTH must be >= 1");
  end
  if (ALMOST_FULL_THRESHOLD > DEPTH) begin : g_chk_af
    $error("fifo_flex: ALMOST_FULL_THRESHOLD must be <= DEPTH");
  end
  if (ALMOST_EMPTY_THRESHOLD >= DEPTH) begin : g_chk_ae
    $error("fifo_flex: ALMOST_EMPTY_THRESHOLD must be < DEPTH");
  end

  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags come only from the count register so they never glitch within a cycle.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
  end

  assign count = count_q;

  // clear overrides both requests, so nothing is accepted on a clear cycle.
  assign wr_acc = wr_en & ~full  & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;

  fifo_flex_mem #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr[INDEX_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr[INDEX_WIDTH-1:0]),
    .rd_data (mem_rd_data)
  );

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
      if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
      if (wr_acc && !rd_acc)      count_q <= count_q + ONE_C;
      else if (rd_acc && !wr_acc) count_q <= count_q - ONE_C;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head word is presented continuously; forced to zero while empty.
    always_comb begin
      rd_data  = empty ? '0 : mem_rd_data;
      rd_valid = ~empty;
    end
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    // Registered read: data and a one-cycle valid pulse follow each accepted pop.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (clear) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem_rd_data;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - directed self-checking bench for fifo_flex in standard and FWFT modes
`timescale 1ns/1ps
module tb_fifo_flex;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;

  logic [7:0] s_rd_data, f_rd_data;
  logic       s_rd_valid, f_rd_valid;
  logic       s_full, f_full, s_empty, f_empty;
  logic       s_af, f_af, s_ae, f_ae;
  logic [4:0] s_count, f_count;
  logic       s_ovf, f_ovf, s_udf, f_udf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_flex #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_flex #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;
    tick(); tick();

    check("rst_count", 32'(s_count), 0);
    check("rst_empty", 32'(s_empty), 1);
    check("rst_full", 32'(s_full), 0);
    check("rst_ae", 32'(s_ae), 1);
    check("rst_af", 32'(s_af), 0);
    check("rst_rd_data", 32'(s_rd_data), 0);
    check("rst_rd_valid", 32'(s_rd_valid), 0);
    check("rst_ovf", 32'(s_ovf), 0);
    check("rst_udf", 32'(s_udf), 0);
    check("rst_f_valid", 32'(f_rd_valid), 0);
    check("rst_f_data", 32'(f_rd_data), 0);
    rst = 1'b0;
    tick();

    // Fill 15 words 0x11..0x1F
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 + i);
      tick();
    end
    wr_en = 1'b0;
    check("fill15_count", 32'(s_count), 15);
    check("fill15_af", 32'(s_af), 1);
    check("fill15_full", 32'(s_full), 0);
    check("fill15_ae", 32'(s_ae), 0);
    check("fill15_f_head", 32'(f_rd_data), 32'h11);
    check("fill15_s_valid", 32'(s_rd_valid), 0);

    wr_en = 1'b1; wr_data = 8'h20; tick(); wr_en = 1'b0;
    check("fill16_full", 32'(s_full), 1);
    check("fill16_count", 32'(s_count), 16);

    wr_en = 1'b1; wr_data = 8'hAA; tick(); wr_en = 1'b0;
    check("ovf_flag", 32'(s_ovf), 1);
    check("ovf_count", 32'(s_count), 16);
    check("ovf_f_flag", 32'(f_ovf), 1);

    // Drain all 16 in order
    for (int i = 0; i < 16; i++) begin
      check("drain_f_head", 32'(f_rd_data), 32'(8'h11 + i));
      rd_en = 1'b1; tick();
      check("drain_s_data", 32'(s_rd_data), 32'(8'h11 + i));
      check("drain_s_valid", 32'(s_rd_valid), 1);
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(s_empty), 1);
    check("drain_f_valid", 32'(f_rd_valid), 0);
    check("drain_f_data", 32'(f_rd_data), 0);
    tick();
    check("pulse_end", 32'(s_rd_valid), 0);
    check("hold_data", 32'(s_rd_data), 32'h20);
    check("ovf_sticky", 32'(s_ovf), 1);
    check("udf_none", 32'(s_udf), 0);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_ovf", 32'(s_ovf), 0);

    // Read latency and FWFT presentation
    wr_en = 1'b1; wr_data = 8'h5A; tick(); wr_en = 1'b0;
    check("fwft_data", 32'(f_rd_data), 32'h5A);
    check("fwft_valid", 32'(f_rd_valid), 1);
    check("std_no_valid", 32'(s_rd_valid), 0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("std_lat_data", 32'(s_rd_data), 32'h5A);
    check("std_lat_valid", 32'(s_rd_valid), 1);
    tick();
    check("std_pulse_once", 32'(s_rd_valid), 0);

    // Simultaneous write/read on empty
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h33; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("sim_empty_count", 32'(s_count), 1);
    check("sim_empty_udf", 32'(s_udf), 1);
    check("sim_empty_ovf", 32'(s_ovf), 0);
    check("sim_empty_f_data", 32'(f_rd_data), 32'h33);
    check("sim_empty_s_valid", 32'(s_rd_valid), 0);

    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i); tick();
    end
    wr_en = 1'b0;
    check("sim_full_pre", 32'(s_full), 1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99; tick();
    wr_en = 1'b0; rd_en = 1'b0;
    check("sim_full_count", 32'(s_count), 15);
    check("sim_full_ovf", 32'(s_ovf), 1);
    check("sim_full_s_data", 32'(s_rd_data), 32'h33);
    check("sim_full_f_head", 32'(f_rd_data), 32'h40);

    clear = 1'b1; tick(); clear = 1'b0;

    // Wrap-around: 40 write/read pairs push pointers past 2*DEPTH
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i); tick(); wr_en = 1'b0;
      check("wrap_count_w", 32'(s_count), 1);
      check("wrap_f_data", 32'(f_rd_data), 32'(8'h80 + i));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      check("wrap_count_r", 32'(s_count), 0);
      check("wrap_s_data", 32'(s_rd_data), 32'(8'h80 + i));
    end

    // Set underflow, fill 9, then clear with a competing write
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("udf_set", 32'(s_udf), 1);
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hE0 + i); tick();
    end
    check("fill9_count", 32'(s_count), 9);
    clear = 1'b1; tick(); clear = 1'b0; wr_en = 1'b0;
    check("clr_count", 32'(s_count), 0);
    check("clr_empty", 32'(s_empty), 1);
    check("clr_udf", 32'(s_udf), 0);
    check("clr_ovf2", 32'(s_ovf), 0);
    check("clr_s_valid", 32'(s_rd_valid), 0);
    check("clr_f_valid", 32'(f_rd_valid), 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i); tick();
    end
    rd_en = 1'b1; tick();
    check("burst_count", 32'(s_count), 5);
    rst = 1'b1;
    #2;
    check("arst_count", 32'(s_count), 0);
    check("arst_empty", 32'(s_empty), 1);
    check("arst_s_data", 32'(s_rd_data), 0);
    check("arst_s_valid", 32'(s_rd_valid), 0);
    check("arst_f_data", 32'(f_rd_data), 0);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    wr_en = 1'b1; wr_data = 8'h77; tick(); wr_en = 1'b0;
    check("post_rst_count", 32'(s_count), 1);
    check("post_rst_f_data", 32'(f_rd_data), 32'h77);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("post_rst_s_data", 32'(s_rd_data), 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised successor to the fixed 8-bit, 16-deep tile FIFO.
- Configurable data width and depth, plus a selectable read mode: standard registered read or first-word-fall-through (FWFT).
- Adds an occupancy count, sticky overflow/underflow error flags and a synchronous clear.
- Sits between the top-level pin wrapper and the datapath, as a drop-in buffer core.

Parameters:
- DATA_WIDTH, 8: bits per entry.
- INDEX_WIDTH, 4: log2 of depth; DEPTH = 1<<INDEX_WIDTH.
- ALMOST_FULL_THRESHOLD, 12: almost_full asserted when count >= this.
- ALMOST_EMPTY_THRESHOLD, 4: almost_empty asserted when count <= this.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties the FIFO and clears the error flags.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read/pop request.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data is valid (see Behaviour).
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_THRESHOLD.
- almost_empty  out  1  count <= ALMOST_EMPTY_THRESHOLD.
- count  out  INDEX_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst high, async):
  - wr_ptr, rd_ptr and count go to 0.
  - rd_data goes to 0; rd_valid, overflow and underflow go to 0.
  - Result: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not reset.
- Pointers:
  - INDEX_WIDTH+1 bits; the low INDEX_WIDTH bits address memory.
  - Wrap-around is natural modulo 2^(INDEX_WIDTH+1).
  - count is registered; no subtraction of pointers on the output path.
- Write acceptance: wr_acc = wr_en & ~full. On acceptance, mem[wr_ptr] <= wr_data and wr_ptr increments.
- Write while full is dropped; overflow <= 1 (sticky until rst or clear).
- Read acceptance: rd_acc = rd_en & ~empty; rd_ptr increments.
- Read while empty is ignored; underflow <= 1 (sticky).
- count update:
  - +1 when only wr_acc.
  - -1 when only rd_acc.
  - unchanged when both or neither.
- Simultaneous events:
  - Full with wr_en & rd_en: read accepted, write rejected, overflow set, count goes DEPTH -> DEPTH-1.
  - Empty with wr_en & rd_en: write accepted, read rejected, underflow set, count goes 0 -> 1.
  - No bypass of same-cycle write data to the read path in either mode.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 on the next cycle (latency 1).
  - rd_valid is a one-cycle pulse per accepted read.
  - rd_data holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] and rd_valid = ~empty, continuously.
  - rd_en acts as a pop/acknowledge of the presented word.
  - When empty, rd_data is forced to 0.
  - First write to an empty FIFO is visible on rd_data one cycle after the write edge.
- Flag derivation: full, empty, almost_* are combinational from the count register only, so they are glitch-free relative to clk.
- clear (synchronous):
  - Pointers and count go to 0; overflow, underflow and rd_valid go to 0.
  - clear takes priority over wr_en/rd_en in the same cycle; neither is accepted and no error flag is set.
- Reset mid-operation: all state is lost immediately; the first post-reset write behaves as a write to an empty FIFO.
- Elaboration checks (reported at elaboration):
  - ALMOST_FULL_THRESHOLD <= DEPTH.
  - ALMOST_EMPTY_THRESHOLD < DEPTH.
  - INDEX_WIDTH >= 1.

Decomposition:
- Shared package fifo_pkg:
  - Default widths/thresholds.
  - Read-mode constants MODE_STANDARD = 0 and MODE_FWFT = 1.
  - A function computing count width from INDEX_WIDTH.
- One sub-module, fifo_flex_mem:
  - Simple dual-port register array, DEPTH x DATA_WIDTH.
  - Synchronous write port, asynchronous read port.
  - Kept separate so it can later be swapped for a macro.
- Control, count, flags and read-mode logic stay in fifo_flex.

Test Plan:
- Reset, then write 0x11..0x1F (15 words, default params) -> count=15, almost_full=1, full=0; 16th write 0x20 -> full=1, count=16.
- Full FIFO, write 0xAA without read -> overflow=1, count stays 16; drain all 16 -> data 0x11..0x20 in order, empty=1.
- FWFT=0: write 0x5A, pulse rd_en -> rd_data=0x5A with rd_valid=1 exactly one cycle after the rd_en edge. FWFT=1: write 0x5A -> rd_data=0x5A, rd_valid=1 with no rd_en.
- Empty FIFO, wr_en=rd_en=1 with 0x33 -> count=1, underflow=1; full FIFO, wr_en=rd_en=1 -> count=15, overflow=1.
- Wrap-around: 40 interleaved write/read pairs with incrementing data -> every read matches its write, count never exceeds 1.
- Fill 9 words, assert clear with wr_en=1 -> count=0, empty=1, flags 0; assert rst mid-burst -> all outputs at reset values immediately.
